serial_utf8_out: RTL and testbench



---
 rtl/serial_utf8_out.sv | 227 ++++++++++++++++++++++
 tb/tb_serial_utf8_out.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_utf8_out.sv
// serial_utf8_out: queues 21-bit code points, encodes each one as UTF-8 and
// shifts the bytes out on tx as 8N1 serial, most significant byte first.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | line high, waiting for the FIFO to become non-empty
//   LOAD  | pop FIFO head, latch encoded bytes and length (one high cycle)
//   START | start bit, tx = 0 for BIT_CYCLES
//   DATA  | 8 data bits, LSB first, BIT_CYCLES each
//   STOP  | stop bit, tx = 1 for BIT_CYCLES, then next byte / LOAD / IDLE
`timescale 1ns/1ps
module serial_utf8_out #(
  parameter int CLK_FREQUENCY_HZ = 108_000_000,
  parameter int SERIAL_BPS       = 2_000_000,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [20:0] unicode,
  input  logic        ie,
  output logic        ready,
  output logic        overflow,
  output logic        busy,
  output logic        tx
);

  localparam int BIT_CYCLES = CLK_FREQUENCY_HZ / SERIAL_BPS;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int FCNT_W     = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BIT_ONE   = CNT_W'(1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // code-point FIFO
  logic [20:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] fifo_count;
  logic              push;
  logic              pop;

  // transmitter
  state_t            state_q;
  state_t            state_n;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [CNT_W-1:0]  bit_cnt_n;
  logic [2:0]        bit_idx_q;
  logic [2:0]        bit_idx_n;
  logic [1:0]        byte_idx_q;
  logic [1:0]        byte_idx_n;
  logic [1:0]        byte_last_q;
  logic [1:0]        byte_last_n;
  logic [31:0]       seq_q;
  logic [31:0]       seq_n;
  logic              tx_n;
  logic [7:0]        cur_byte;

  // encoder
  logic [20:0]       head_cp;
  logic [20:0]       cp_fix;
  logic [31:0]       enc_seq;
  logic [1:0]        enc_last;

  assign ready    = (fifo_count != FIFO_FULL);
  assign push     = ie & ready;
  assign busy     = (fifo_count != '0) || (state_q != S_IDLE);
  assign head_cp  = fifo_mem[rd_ptr];
  assign cur_byte = seq_q[31:24];

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= unicode;
  end

  // FIFO pointers, occupancy and the overflow pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_ONE;
        2'b01:   fifo_count <= fifo_count - FCNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      overflow <= ie & ~ready;
    end
  end

  // UTF-8 encode of the FIFO head; surrogates and out-of-range become U+FFFD.
  // Bytes are left-aligned so the byte on the wire is always seq_q[31:24].
  always_comb begin
    cp_fix = head_cp;
    if ((head_cp >= 21'h00D800 && head_cp <= 21'h00DFFF) || head_cp > 21'h10FFFF)
      cp_fix = 21'h00FFFD;
    enc_seq  = 32'h0;
    enc_last = 2'd0;
    if (cp_fix < 21'h000080) begin
      enc_seq  = {cp_fix[7:0], 24'h0};
      enc_last = 2'd0;
    end else if (cp_fix < 21'h000800) begin
      enc_seq  = {3'b110, cp_fix[10:6], 2'b10, cp_fix[5:0], 16'h0};
      enc_last = 2'd1;
    end else if (cp_fix < 21'h010000) begin
      enc_seq  = {4'b1110, cp_fix[15:12], 2'b10, cp_fix[11:6],
                  2'b10, cp_fix[5:0], 8'h0};
      enc_last = 2'd2;
    end else begin
      enc_seq  = {5'b11110, cp_fix[20:18], 2'b10, cp_fix[17:12],
                  2'b10, cp_fix[11:6], 2'b10, cp_fix[5:0]};
      enc_last = 2'd3;
    end
  end

  // transmitter state register; tx is registered so the line never glitches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      byte_last_q <= '0;
      seq_q       <= '0;
      tx          <= 1'b1;
    end else begin
      state_q     <= state_n;
      bit_cnt_q   <= bit_cnt_n;
      bit_idx_q   <= bit_idx_n;
      byte_idx_q  <= byte_idx_n;
      byte_last_q <= byte_last_n;
      seq_q       <= seq_n;
      tx          <= tx_n;
    end
  end

  // next-state logic; tx_n is the line level for the cycle after the edge,
  // bit timing uses a down-counter reloaded with BIT_CYCLES-1
  always_comb begin
    state_n     = state_q;
    bit_cnt_n   = bit_cnt_q;
    bit_idx_n   = bit_idx_q;
    byte_idx_n  = byte_idx_q;
    byte_last_n = byte_last_q;
    seq_n       = seq_q;
    tx_n        = tx;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_n = 1'b1;
        if (fifo_count != '0) state_n = S_LOAD;
      end
      S_LOAD: begin
        pop         = 1'b1;
        seq_n       = enc_seq;
        byte_last_n = enc_last;
        byte_idx_n  = '0;
        bit_cnt_n   = BIT_LAST;
        tx_n        = 1'b0;
        state_n     = S_START;
      end
      S_START: begin
        if (bit_cnt_q == '0) begin
          bit_cnt_n = BIT_LAST;
          bit_idx_n = '0;
          tx_n      = seq_q[24];
          state_n   = S_DATA;
        end else begin
          bit_cnt_n = bit_cnt_q - BIT_ONE;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == '0) begin
          bit_cnt_n = BIT_LAST;
          if (bit_idx_q == 3'd7) begin
            tx_n    = 1'b1;
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx_q + 3'd1;
            tx_n      = cur_byte[bit_idx_n];
          end
        end else begin
          bit_cnt_n = bit_cnt_q - BIT_ONE;
        end
      end
      S_STOP: begin
        if (bit_cnt_q == '0) begin
          if (byte_idx_q != byte_last_q) begin
            byte_idx_n = byte_idx_q + 2'd1;
            seq_n      = {seq_q[23:0], 8'h00};
            bit_cnt_n  = BIT_LAST;
            tx_n       = 1'b0;
            state_n    = S_START;
          end else if (fifo_count != '0) begin
            tx_n    = 1'b1;
            state_n = S_LOAD;
          end else begin
            tx_n    = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt_q - BIT_ONE;
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_utf8_out.sv
// Bench for serial_utf8_out: a cycle-level line model built from the UTF-8
// and 8N1 framing rules, a line receiver, and directed code-point tests.
`timescale 1ns/1ps
module tb_serial_utf8_out;

  localparam int BIT   = 54;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [20:0] unicode;
  logic        ie;
  logic        ready;
  logic        overflow;
  logic        busy;
  logic        tx;

  serial_utf8_out dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .unicode  (unicode),
    .ie       (ie),
    .ready    (ready),
    .overflow (overflow),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // ---------------- line model ----------------
  int unsigned cpq[$];
  logic        wave[$];
  bit          pending = 1'b0;
  int          cyc = 0;
  int          last_push_cyc = 0;
  logic        exp_tx = 1'b1;
  logic        exp_ready = 1'b1;
  logic        exp_busy = 1'b0;
  logic        exp_ovf = 1'b0;

  function automatic void add_frame(input logic [7:0] b);
    for (int k = 0; k < BIT; k++) wave.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < BIT; k++) wave.push_back(b[i]);
    for (int k = 0; k < BIT; k++) wave.push_back(1'b1);
  endfunction

  function automatic void add_sequence(input int unsigned cp_in);
    int unsigned cp;
    int n;
    logic [7:0] b;
    cp = cp_in;
    if ((cp >= 32'hD800 && cp <= 32'hDFFF) || cp > 32'h10FFFF) cp = 32'hFFFD;
    n = (cp < 32'h80) ? 1 : (cp < 32'h800) ? 2 : (cp < 32'h10000) ? 3 : 4;
    case (n)
      1:       b = 8'(cp);
      2:       b = 8'h C0 | 8'(cp >> 6);
      3:       b = 8'hE0 | 8'(cp >> 12);
      default: b = 8'hF0 | 8'(cp >> 18);
    endcase
    add_frame(b);
    for (int i = 1; i < n; i++) begin
      b = 8'h80 | 8'((cp >> (6 * (n - 1 - i))) & 32'h3F);
      add_frame(b);
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpq.delete();
      wave.delete();
      pending   = 1'b0;
      exp_tx    = 1'b1;
      exp_ready = 1'b1;
      exp_busy  = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      bit accept;
      bit active;
      cyc++;
      accept = (cpq.size() < DEPTH);
      active = 1'b0;
      if (wave.size() > 0) begin
        exp_tx = wave.pop_front();
        active = 1'b1;
      end else if (pending) begin
        add_sequence(cpq.pop_front());
        exp_tx  = wave.pop_front();
        pending = 1'b0;
        active  = 1'b1;
      end else begin
        exp_tx = 1'b1;
        if (cpq.size() > 0) pending = 1'b1;
      end
      if (ie && accept) begin
        cpq.push_back(32'(unicode));
        last_push_cyc = cyc;
      end
      exp_ovf   = ie && !accept;
      exp_ready = (cpq.size() < DEPTH);
      exp_busy  = active || pending || (cpq.size() > 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  int   ovf_seen = 0;
  int   ready_low_seen = 0;
  int   tx_low_seen = 0;
  int   busy_fall_cyc = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    chk("tx",       32'(tx),       32'(exp_tx));
    chk("ready",    32'(ready),    32'(exp_ready));
    chk("busy",     32'(busy),     32'(exp_busy));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (overflow === 1'b1) ovf_seen++;
    if (ready === 1'b0) ready_low_seen++;
    if (tx === 1'b0) tx_low_seen++;
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    busy_prev = busy;
  end

  // ---------------- line receiver ----------------
  logic [7:0] rx_q[$];
  int         rx_start[$];
  bit         mon_active = 1'b0;
  int         mon_t = 0;
  int         mon_start = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_t      = 0;
        mon_start  = cyc;
      end
    end else begin
      mon_t++;
      if (mon_t > BIT && mon_t < 9 * BIT && (mon_t % BIT) == BIT / 2)
        mon_byte[(mon_t - BIT / 2) / BIT - 1] = tx;
      if (mon_t == 9 * BIT + BIT / 2) begin
        chk("stop_bit", 32'(tx), 32'd1);
        rx_q.push_back(mon_byte);
        rx_start.push_back(mon_start);
        mon_active = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] exp_q[$];

  task automatic send(input logic [20:0] cp);
    ie = 1'b1;
    unicode = cp;
    @(posedge clk); #1;
    ie = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_rx(input string name);
    chk({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) chk({name, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    rx_start.delete();
  endtask

  function automatic int start_gap();
    if (rx_start.size() < 2) return -1;
    return rx_start[1] - rx_start[0];
  endfunction

  // ---------------- tests ----------------
  initial begin
    int s0;
    reset_n = 1'b0;
    ie      = 1'b0;
    unicode = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_tx",    32'(tx),       32'd1);
    chk("reset_ready", 32'(ready),    32'd1);
    chk("reset_busy",  32'(busy),     32'd0);
    chk("reset_ovf",   32'(overflow), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: single ASCII byte, latency and busy length
    send(21'h000041);
    wait_idle(2000);
    s0 = (rx_start.size() > 0) ? rx_start[0] : -1000;
    chk("t1_latency",   32'(s0 - last_push_cyc), 32'd2);
    chk("t1_busy_fall", 32'(busy_fall_cyc - s0), 32'd540);
    exp_q = '{8'h41};
    check_rx("t1");

    // 2: multi-byte sequences
    send(21'h0000E9);
    wait_idle(3000);
    chk("t2_contig", 32'(start_gap()), 32'd540);
    exp_q = '{8'hC3, 8'hA9};
    check_rx("t2a");
    send(21'h0020AC);
    wait_idle(3000);
    exp_q = '{8'hE2, 8'h82, 8'hAC};
    check_rx("t2b");
    send(21'h01F600);
    wait_idle(4000);
    exp_q = '{8'hF0, 8'h9F, 8'h98, 8'h80};
    check_rx("t2c");

    // 3: replacement and top of range
    send(21'h110000);
    send(21'h00D800);
    send(21'h10FFFF);
    wait_idle(8000);
    exp_q = '{8'hEF, 8'hBF, 8'hBD, 8'hEF, 8'hBF, 8'hBD, 8'hF4, 8'h8F, 8'hBF, 8'hBF};
    check_rx("t3");

    // 4: fill past full
    ovf_seen = 0;
    for (int i = 0; i < 18; i++) begin
      ie = 1'b1;
      unicode = 21'(32'h41 + i);
      @(posedge clk); #1;
      if (i == 16) chk("t4_ready_low", 32'(ready), 32'd0);
      if (i == 17) chk("t4_ovf_pulse", 32'(overflow), 32'd1);
    end
    ie = 1'b0;
    wait_idle(12000);
    chk("t4_ovf_count", 32'(ovf_seen), 32'd1);
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(8'(8'h41 + i));
    check_rx("t4");

    // 5: one LOAD gap between two sequences
    ready_low_seen = 0;
    send(21'h000030);
    send(21'h000031);
    wait_idle(3000);
    chk("t5_gap",       32'(start_gap()), 32'd541);
    chk("t5_ready_low", 32'(ready_low_seen), 32'd0);
    exp_q = '{8'h30, 8'h31};
    check_rx("t5");

    // 6: reset in the middle of a 3-byte sequence with 5 queued
    send(21'h0020AC);
    for (int i = 0; i < 5; i++) send(21'(32'h61 + i));
    repeat (150) begin @(posedge clk); #1; end
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_tx",    32'(tx),    32'd1);
    chk("t6_busy",  32'(busy),  32'd0);
    chk("t6_ready", 32'(ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rx_q.delete();
    rx_start.delete();
    tx_low_seen = 0;
    repeat (2000) begin @(posedge clk); #1; end
    chk("t6_tx_low",  32'(tx_low_seen), 32'd0);
    chk("t6_no_rx",   32'(rx_q.size()), 32'd0);
    chk("t6_idle",    32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
